menu_flow_ctrl: RTL and testbench
=================================

// Module: menu_flow_ctrl
// PURPOSE
//  System-level front-end FSM feeding DiceRace top: turns raw BtnU/BtnD into debounced single-cycle presses and
//  sequences INTRO menu -> GAME -> RESULT -> INTRO, or INTRO -> END. Drives is_intro/menu_select to UI_Generator,
//  gated start/event ticks plus a game_clear pulse to Game_Logic_Controller, and consumes its winner_valid.
// PARAMETERS
//  DB_CYCLES           1_000_000    clk cycles a synchronised button level must hold to be accepted (10 ms @100 MHz)
//  RESULT_HOLD_CYCLES  500_000_000  clk cycles RESULT screen is held before auto-return to INTRO (5 s)
// PORTS
//  clk              in   1  system clock; single clock domain
//  reset            in   1  synchronous, active-low reset (0 = reset)
//  start_btn        in   1  raw BtnU, asynchronous to clk
//  select_option    in   1  raw BtnD, asynchronous to clk
//  winner_valid     in   1  level from game logic; high once a player has won
//  state_code       out  3  current menu_state_t encoding (debug/LED)
//  is_intro         out  1  state == INTRO
//  is_game          out  1  state == GAME
//  is_result        out  1  state == RESULT
//  is_end           out  1  state == END
//  menu_select      out  1  0 = Start, 1 = End (intro cursor)
//  game_clear       out  1  1-cycle pulse: clear positions/turn in game logic
//  game_start_tick  out  1  1-cycle pulse: BtnU press while in GAME
//  event_tick       out  1  1-cycle pulse: BtnD press while in GAME
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=INTRO, menu_select=0, all pulses 0, sync/debounce regs 0, hold counter 0,
//   press_armed=0 per button. Outputs reflect INTRO on the first cycle after reset releases.
//  Button path (per button): 2-FF synchroniser -> counter; debounced level changes only after DB_CYCLES consecutive
//   cycles at the new level; press = 1-cycle pulse on debounced 0->1. Press latency from stable raw edge:
//   2 + DB_CYCLES + 1 cycles. press_armed sets on the first debounced low after reset; presses while unarmed are
//   dropped (a button held through reset never produces a press).
//  FSM (registered outputs, decode from state reg):
//   INTRO : up_press & menu_select==0 -> GAME_ARM; up_press & menu_select==1 -> END;
//           dn_press & !up_press -> menu_select toggles. Simultaneous up+dn: up wins, no toggle.
//   GAME_ARM: exactly 1 cycle; game_clear=1 this cycle; -> GAME unconditionally.
//   GAME  : game_start_tick=up_press, event_tick=dn_press (same cycle as press). winner_valid==1 -> RESULT,
//           hold counter loaded with RESULT_HOLD_CYCLES-1; a press in that same cycle is still forwarded.
//   RESULT: counter decrements each cycle; counter==0 or up_press -> INTRO with menu_select<=0. dn_press ignored.
//           No ticks forwarded.
//   END   : all ticks 0; up_press -> INTRO, menu_select<=0. Only exit besides reset.
//  game_start_tick/event_tick/game_clear are 0 in every state except as listed; never more than 1 cycle wide.
//  Widths: debounce counter $clog2(DB_CYCLES+1); hold counter $clog2(RESULT_HOLD_CYCLES); no wrap (saturate at 0).
//  Reset mid-operation (any state, mid-debounce, mid-hold): everything returns to reset values next edge.
//  Illegal state encodings recover to INTRO on the next cycle.
// STRUCTURE
//  dice_race_pkg: typedef enum logic [2:0] menu_state_t {MS_INTRO=0, MS_GAME_ARM=1, MS_GAME=2,
//   MS_RESULT=3, MS_END=4}; localparams MENU_START=1'b0, MENU_END=1'b1.
//  Sub-module btn_press_filter (sync + debounce + arm + rising-edge pulse, param DB_CYCLES), instantiated twice;
//  FSM, hold counter and output decode in menu_flow_ctrl.
// TESTING (DB_CYCLES=4, RESULT_HOLD_CYCLES=10)
//  1 reset=0 for 3 cycles, btn held high through release -> no press, state_code=0; release+repress -> 1 press.
//  2 INTRO: BtnD bounce 1-0-1 in 3 cycles then hold 8 -> exactly one toggle, menu_select=1, 7 cycles after stable.
//  3 INTRO menu_select=0, BtnU press -> game_clear 1 cycle (state 1), then state=2; BtnU/BtnD in GAME ->
//    one game_start_tick / one event_tick each.
//  4 GAME, winner_valid=1 -> RESULT; no input -> INTRO exactly 10 cycles later, menu_select=0; repeat with BtnU
//    at hold count 5 -> INTRO on the press.
//  5 INTRO menu_select=1, simultaneous BtnU+BtnD -> END, menu_select unchanged; BtnU in END -> INTRO.
//  6 reset asserted mid-RESULT and mid-debounce -> all outputs at reset values next cycle, no stray pulses.

Source files
------------

// File: rtl/dice_race_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dice_race_pkg
//  Description : Shared types and constants for the DiceRace front-end menu
//                flow. Holds the menu state encoding and the intro-cursor
//                values used by menu_flow_ctrl and the UI.
//  Revision    : 1.0 - initial release
// ============================================================================
package dice_race_pkg;

    // Menu state encoding; also exported on state_code for debug LEDs.
    typedef enum logic [2:0] {
        MS_INTRO    = 3'd0,
        MS_GAME_ARM = 3'd1,
        MS_GAME     = 3'd2,
        MS_RESULT   = 3'd3,
        MS_END      = 3'd4
    } menu_state_t;

    // Intro cursor values for menu_select.
    localparam logic MENU_START = 1'b0;
    localparam logic MENU_END   = 1'b1;

endpackage : dice_race_pkg
`default_nettype wire

// File: rtl/btn_press_filter.sv
`default_nettype none
// ============================================================================
//  Module      : btn_press_filter
//  Description : Turns one raw, asynchronous push-button into a clean
//                single-cycle press pulse: 2-FF synchroniser, level
//                debouncer, power-up arming and rising-edge detection.
//  Ports       : clk     - system clock
//                reset   - synchronous active-low reset (0 = reset)
//                btn_raw - raw button level, asynchronous to clk
//                press   - 1-cycle pulse on each accepted debounced 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_press_filter #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_db;
    logic               r_db_d;
    logic               r_armed;
    logic               r_press;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic [c_CNT_W-1:0] r_arm_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db      <= 1'b0;
            r_db_d    <= 1'b0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
            r_db_cnt  <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;

            // Debounce: the accepted level only moves after the synchronised
            // level has disagreed with it for DB_CYCLES consecutive cycles.
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_CNT_LAST) begin
                r_db     <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            // Arming needs a genuinely observed low: the debounced level is
            // low AND the synchroniser has shown low for DB_CYCLES cycles.
            // The reset-cleared sync stages alone cannot arm, so a button
            // held through reset never yields a press.
            if (!r_armed) begin
                if (!r_db && !r_sync2) begin
                    if (r_arm_cnt == c_CNT_LAST) begin
                        r_armed <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end else begin
                    r_arm_cnt <= '0;
                end
            end

            // Registered edge detect: one cycle after the debounced rise.
            r_press <= r_armed & r_db & ~r_db_d;
        end
    end

    assign press = r_press;

endmodule : btn_press_filter
`default_nettype wire

// File: rtl/menu_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : menu_flow_ctrl
//  Description : Front-end menu FSM for DiceRace. Filters BtnU/BtnD into
//                single-cycle presses and sequences
//                INTRO -> GAME_ARM -> GAME -> RESULT -> INTRO, or
//                INTRO -> END -> INTRO. Gates button ticks into the game
//                logic and issues a one-cycle game_clear on game entry.
//  Ports       : clk, reset (sync, active-low), start_btn (BtnU),
//                select_option (BtnD), winner_valid (from game logic)
//                state_code[2:0], is_intro/is_game/is_result/is_end,
//                menu_select (0 Start / 1 End), game_clear,
//                game_start_tick, event_tick
//  Revision    : 1.0 - initial release
// ============================================================================
module menu_flow_ctrl
    import dice_race_pkg::*;
#(
    parameter int DB_CYCLES          = 1_000_000,
    parameter int RESULT_HOLD_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       select_option,
    input  logic       winner_valid,
    output logic [2:0] state_code,
    output logic       is_intro,
    output logic       is_game,
    output logic       is_result,
    output logic       is_end,
    output logic       menu_select,
    output logic       game_clear,
    output logic       game_start_tick,
    output logic       event_tick
);

    localparam int                  c_HOLD_W    = (RESULT_HOLD_CYCLES > 1) ?
                                                  $clog2(RESULT_HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(RESULT_HOLD_CYCLES - 1);

    logic                w_up_press;
    logic                w_dn_press;

    menu_state_t         r_state;
    menu_state_t         w_state_next;
    logic                r_menu_select;
    logic                w_menu_select_next;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_next;

    btn_press_filter #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (start_btn),
        .press   (w_up_press)
    );

    btn_press_filter #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (select_option),
        .press   (w_dn_press)
    );

    // State register (with the cursor and RESULT hold counter).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= MS_INTRO;
            r_menu_select <= MENU_START;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_menu_select <= w_menu_select_next;
            r_hold_cnt    <= w_hold_cnt_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next       = r_state;
        w_menu_select_next = r_menu_select;
        w_hold_cnt_next    = r_hold_cnt;
        case (r_state)
            MS_INTRO: begin
                // BtnU takes priority; a simultaneous BtnD is discarded.
                if (w_up_press) begin
                    w_state_next = (r_menu_select == MENU_START) ? MS_GAME_ARM : MS_END;
                end else if (w_dn_press) begin
                    w_menu_select_next = ~r_menu_select;
                end
            end
            MS_GAME_ARM: begin
                w_state_next = MS_GAME;
            end
            MS_GAME: begin
                if (winner_valid) begin
                    w_state_next    = MS_RESULT;
                    w_hold_cnt_next = c_HOLD_LOAD;
                end
            end
            MS_RESULT: begin
                // Exiting at zero means the counter never decrements past 0.
                if ((r_hold_cnt == '0) || w_up_press) begin
                    w_state_next       = MS_INTRO;
                    w_menu_select_next = MENU_START;
                    w_hold_cnt_next    = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 1'b1;
                end
            end
            MS_END: begin
                if (w_up_press) begin
                    w_state_next       = MS_INTRO;
                    w_menu_select_next = MENU_START;
                end
            end
            default: begin
                w_state_next = MS_INTRO;
            end
        endcase
    end

    // Output decode from registered state. Ticks combine the registered
    // state with the registered press so they appear in the press cycle.
    always_comb begin
        state_code      = r_state;
        is_intro        = (r_state == MS_INTRO);
        is_game         = (r_state == MS_GAME);
        is_result       = (r_state == MS_RESULT);
        is_end          = (r_state == MS_END);
        menu_select     = r_menu_select;
        game_clear      = (r_state == MS_GAME_ARM);
        game_start_tick = (r_state == MS_GAME) & w_up_press;
        event_tick      = (r_state == MS_GAME) & w_dn_press;
    end

endmodule : menu_flow_ctrl
`default_nettype wire

// File: tb/tb_menu_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_menu_flow_ctrl
//  Description : Directed self-checking bench for menu_flow_ctrl with
//                DB_CYCLES=4 and RESULT_HOLD_CYCLES=10. A press appears
//                7 edges after a stable raw edge; the FSM reacts one edge
//                later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       select_option;
    logic       winner_valid;
    logic [2:0] state_code;
    logic       is_intro;
    logic       is_game;
    logic       is_result;
    logic       is_end;
    logic       menu_select;
    logic       game_clear;
    logic       game_start_tick;
    logic       event_tick;

    int checks = 0;
    int errors = 0;

    menu_flow_ctrl #(
        .DB_CYCLES          (4),
        .RESULT_HOLD_CYCLES (10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_btn       (start_btn),
        .select_option   (select_option),
        .winner_valid    (winner_valid),
        .state_code      (state_code),
        .is_intro        (is_intro),
        .is_game         (is_game),
        .is_result       (is_result),
        .is_end          (is_end),
        .menu_select     (menu_select),
        .game_clear      (game_clear),
        .game_start_tick (game_start_tick),
        .event_tick      (event_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From INTRO with cursor on Start: press BtnU and settle in GAME.
    task automatic go_game();
        start_btn = 1'b1;
        steps(9);
        chk("go_game_state", 32'(state_code), 32'd2);
        start_btn = 1'b0;
        steps(16);
    endtask

    int n_gst;
    int n_evt;
    int idx;
    int bad;

    initial begin
        reset         = 1'b0;
        start_btn     = 1'b0;
        select_option = 1'b1;
        winner_valid  = 1'b0;

        // ---- 1: BtnD held through reset never produces a press ----------
        steps(3);
        reset = 1'b1;
        chk("rst_state",  32'(state_code),      32'd0);
        chk("rst_intro",  32'(is_intro),        32'd1);
        chk("rst_sel",    32'(menu_select),     32'd0);
        chk("rst_clear",  32'(game_clear),      32'd0);
        chk("rst_gst",    32'(game_start_tick), 32'd0);
        chk("rst_evt",    32'(event_tick),      32'd0);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (menu_select !== 1'b0 || state_code !== 3'd0) bad++;
        end
        chk("held_no_press", 32'(bad), 32'd0);
        select_option = 1'b0;
        steps(16);

        // ---- 2: bounced BtnD -> exactly one toggle -----------------------
        select_option = 1'b1; step();
        select_option = 1'b0; step();
        select_option = 1'b1;
        steps(7);
        chk("bounce_sel_pre",  32'(menu_select), 32'd0);
        step();
        chk("bounce_sel_post", 32'(menu_select), 32'd1);
        steps(8);
        chk("bounce_sel_hold", 32'(menu_select), 32'd1);
        select_option = 1'b0;
        steps(16);
        chk("bounce_one_toggle", 32'(menu_select), 32'd1);

        // ---- 5: simultaneous BtnU+BtnD with cursor on End -> END ---------
        start_btn     = 1'b1;
        select_option = 1'b1;
        steps(7);
        chk("end_pre_state", 32'(state_code), 32'd0);
        step();
        chk("end_state",     32'(state_code),  32'd4);
        chk("end_is_end",    32'(is_end),      32'd1);
        chk("end_sel_kept",  32'(menu_select), 32'd1);
        start_btn     = 1'b0;
        select_option = 1'b0;
        steps(16);
        chk("end_stays", 32'(state_code), 32'd4);
        start_btn = 1'b1;
        steps(7);
        chk("end_exit_pre", 32'(state_code), 32'd4);
        step();
        chk("end_exit_state", 32'(state_code),  32'd0);
        chk("end_exit_sel",   32'(menu_select), 32'd0);
        start_btn = 1'b0;
        steps(16);

        // ---- 3: Start -> GAME_ARM (game_clear) -> GAME, ticks ------------
        start_btn = 1'b1;
        steps(7);
        chk("arm_pre_state", 32'(state_code), 32'd0);
        chk("arm_pre_clear", 32'(game_clear), 32'd0);
        step();
        chk("arm_state", 32'(state_code), 32'd1);
        chk("arm_clear", 32'(game_clear), 32'd1);
        step();
        chk("game_state",   32'(state_code), 32'd2);
        chk("game_is_game", 32'(is_game),    32'd1);
        chk("game_clear_1", 32'(game_clear), 32'd0);
        start_btn = 1'b0;
        steps(16);

        start_btn = 1'b1;
        n_gst = 0; n_evt = 0; idx = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (game_start_tick === 1'b1) begin n_gst++; if (idx < 0) idx = k; end
            if (event_tick === 1'b1) n_evt++;
        end
        chk("gst_count", 32'(n_gst), 32'd1);
        chk("gst_at",    32'(idx),   32'd7);
        chk("gst_no_evt", 32'(n_evt), 32'd0);
        start_btn = 1'b0;
        steps(16);

        select_option = 1'b1;
        n_gst = 0; n_evt = 0; idx = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (event_tick === 1'b1) begin n_evt++; if (idx < 0) idx = k; end
            if (game_start_tick === 1'b1) n_gst++;
        end
        chk("evt_count",  32'(n_evt), 32'd1);
        chk("evt_at",     32'(idx),   32'd7);
        chk("evt_no_gst", 32'(n_gst), 32'd0);
        chk("evt_sel",    32'(menu_select), 32'd0);
        select_option = 1'b0;
        steps(16);

        // ---- 4: winner -> RESULT -> timeout back to INTRO ----------------
        winner_valid = 1'b1;
        step();
        chk("res_state",     32'(state_code), 32'd3);
        chk("res_is_result", 32'(is_result),  32'd1);
        winner_valid = 1'b0;
        idx = -1; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (idx < 0 && state_code === 3'd0) idx = k;
            if (game_start_tick !== 1'b0 || event_tick !== 1'b0 || game_clear !== 1'b0) bad++;
        end
        chk("res_timeout_at", 32'(idx), 32'd10);
        chk("res_no_pulses",  32'(bad), 32'd0);
        chk("res_exit_sel",   32'(menu_select), 32'd0);

        // RESULT cut short by BtnU arriving at hold count 5.
        go_game();
        start_btn = 1'b1;
        steps(2);
        winner_valid = 1'b1;
        step();
        chk("res2_state", 32'(state_code), 32'd3);
        winner_valid = 1'b0;
        steps(4);
        chk("res2_pre_state", 32'(state_code),      32'd3);
        chk("res2_no_tick",   32'(game_start_tick), 32'd0);
        step();
        chk("res2_exit_state", 32'(state_code),  32'd0);
        chk("res2_exit_sel",   32'(menu_select), 32'd0);
        start_btn = 1'b0;
        steps(16);

        // ---- 6: reset mid-RESULT and mid-debounce ------------------------
        go_game();
        winner_valid = 1'b1;
        step();
        winner_valid = 1'b0;
        chk("rst2_in_result", 32'(state_code), 32'd3);
        steps(3);
        select_option = 1'b1;
        steps(3);
        reset = 1'b0;
        step();
        chk("rst2_state",  32'(state_code),      32'd0);
        chk("rst2_intro",  32'(is_intro),        32'd1);
        chk("rst2_result", 32'(is_result),       32'd0);
        chk("rst2_sel",    32'(menu_select),     32'd0);
        chk("rst2_pulses", 32'({game_clear, game_start_tick, event_tick}), 32'd0);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (state_code !== 3'd0 || menu_select !== 1'b0 || game_clear !== 1'b0) bad++;
        end
        chk("rst2_no_stray", 32'(bad), 32'd0);
        select_option = 1'b0;
        steps(16);
        select_option = 1'b1;
        steps(8);
        chk("rst2_recover_sel", 32'(menu_select), 32'd1);
        select_option = 1'b0;
        steps(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_menu_flow_ctrl
`default_nettype wire
